// File: rtl/comparator_sweeper.sv
// Exhaustive x/y stimulus driver and checker for an unsigned le/eq comparator.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module comparator_sweeper #(
  parameter int W      = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 2*W+1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  input  logic             le_in,
  input  logic             eq_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [W-1:0]     fail_x,
  output logic [W-1:0]     fail_y
);

  localparam int VW = 2*W;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [VW-1:0]    v_r, v_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [CNT_W-1:0] err_r, err_s;
  logic             fv_r, fv_s;
  logic [W-1:0]     fx_r, fx_s;
  logic [W-1:0]     fy_r, fy_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             mismatch_s;
  logic             last_s;

  // Golden unsigned compare; a vector with both results wrong is still one mismatch
  function automatic logic vec_mismatch(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic le, input logic eq);
    return (le != (x <= y)) || (eq != (x == y));
  endfunction

  // Mismatch of the applied vector and end-of-sweep condition
  always_comb begin
    mismatch_s = vec_mismatch(v_r[VW-1:W], v_r[W-1:0], le_in, eq_in);
`ifdef SWEEP_STOP_ON_FAIL_EN
    last_s = (&v_r) || mismatch_s;
`else
    last_s = &v_r;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    v_s     = v_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    fv_s    = fv_r;
    fx_s    = fx_r;
    fy_s    = fy_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = APPLY;
          v_s     = {VW{1'b0}};
          cnt_s   = 4'd0;
          err_s   = {CNT_W{1'b0}};
          fv_s    = 1'b0;
          fx_s    = {W{1'b0}};
          fy_s    = {W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      APPLY: begin
        if (cnt_r == SETTLE_C) begin
          if (mismatch_s) begin
            err_s = err_r + CNT_W'(1'b1);
            if (!fv_r) begin
              fv_s = 1'b1;
              fx_s = v_r[VW-1:W];
              fy_s = v_r[W-1:0];
            end else begin
              fv_s = fv_r;
            end
          end else begin
            err_s = err_r;
          end
          // The final (or, when stopping on fail, failing) vector stays on the bus
          if (last_s) begin
            state_s = DONE;
          end else begin
            v_s   = v_r + VW'(1'b1);
            cnt_s = 4'd0;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == APPLY);
    done_s = (state_s == DONE);
    pass_s = (state_s == DONE) && (err_s == {CNT_W{1'b0}});
  end

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      v_r     <= {VW{1'b0}};
      cnt_r   <= 4'd0;
      err_r   <= {CNT_W{1'b0}};
      fv_r    <= 1'b0;
      fx_r    <= {W{1'b0}};
      fy_r    <= {W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      v_r     <= v_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      fv_r    <= fv_s;
      fx_r    <= fx_s;
      fy_r    <= fy_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign x_out      = v_r[VW-1:W];
  assign y_out      = v_r[W-1:0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_valid = fv_r;
  assign fail_x     = fx_r;
  assign fail_y     = fy_r;

endmodule

// File: tb/tb_comparator_sweeper.sv
// Self-checking bench: comparator with injectable faults, per-cycle model compare
// plus literal checks. Two instances: SETTLE=1 (main) and SETTLE=0 (latency).
module tb_comparator_sweeper;

  localparam int W     = 2;
  localparam int S     = 1;
  localparam int NV    = 16;
  localparam int CNT_W = 2*W+1;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;

  logic [W-1:0] x_out, y_out, fail_x, fail_y;
  logic le_in, eq_in, busy, done, pass, fail_valid;
  logic [CNT_W-1:0] err_count;

  logic [W-1:0] x0, y0, fx0, fy0;
  logic le0, eq0, busy0, done0, pass0, fv0;
  logic [CNT_W-1:0] err0;

  bit fle[NV];
  bit feq[NV];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // Comparator under test: correct unless the fault tables flip a result
  assign le_in = (x_out <= y_out) ^ fle[{x_out, y_out}];
  assign eq_in = (x_out == y_out) ^ feq[{x_out, y_out}];
  assign le0   = (x0 <= y0) ^ fle[{x0, y0}];
  assign eq0   = (x0 == y0) ^ feq[{x0, y0}];

  comparator_sweeper #(.W(W), .SETTLE(S), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .resetn(resetn), .start(start),
    .x_out(x_out), .y_out(y_out), .le_in(le_in), .eq_in(eq_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_x(fail_x), .fail_y(fail_y)
  );

  comparator_sweeper #(.W(W), .SETTLE(0), .CNT_W(CNT_W)) u_dut0 (
    .clock(clock), .resetn(resetn), .start(start0),
    .x_out(x0), .y_out(y0), .le_in(le0), .eq_in(eq0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_x(fx0), .fail_y(fy0)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mf[NV];          // faulty vectors of the sweep in progress
  int m_state = 0;     // 0 idle, 1 sweeping, 2 done
  int m_t = 0;         // cycles since first APPLY cycle

  function automatic int faults_below(input int k);
    int c = 0;
    for (int i = 0; i < k; i++) if (mf[i]) c++;
    return c;
  endfunction

  function automatic int first_below(input int k);
    for (int i = 0; i < k; i++) if (mf[i]) return i;
    return -1;
  endfunction

  function automatic int sweep_len();
    int ff = first_below(NV);
    if (STOP && ff >= 0) return (ff + 1) * (S + 1);
    return NV * (S + 1);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_state <= 0;
      m_t <= 0;
    end else if (m_state == 1) begin
      if (m_t == sweep_len() - 1) m_state <= 2;
      else m_t <= m_t + 1;
    end else if (start) begin
      m_state <= 1;
      m_t <= 0;
      for (int i = 0; i < NV; i++) mf[i] <= fle[i] | feq[i];
    end
  end

  int ex_v, ex_err, ex_fi, ex_busy, ex_done, ex_pass, ex_k;

  // Compare every cycle, away from the active edge
  always @(negedge clock) begin
    ex_v = 0; ex_err = 0; ex_fi = -1; ex_busy = 0; ex_done = 0; ex_pass = 0;
    if (m_state == 1) begin
      ex_k = m_t / (S + 1);
      ex_v = ex_k;
      ex_err = faults_below(ex_k);
      ex_fi = first_below(ex_k);
      ex_busy = 1;
    end else if (m_state == 2) begin
      ex_fi = first_below(NV);
      if (STOP && ex_fi >= 0) begin
        ex_v = ex_fi;
        ex_err = 1;
      end else begin
        ex_v = NV - 1;
        ex_err = faults_below(NV);
      end
      ex_done = 1;
      ex_pass = (ex_err == 0) ? 1 : 0;
    end
    chk("x_out", int'(x_out), ex_v / 4);
    chk("y_out", int'(y_out), ex_v % 4);
    chk("busy", int'(busy), ex_busy);
    chk("done", int'(done), ex_done);
    chk("pass", int'(pass), ex_pass);
    chk("err_count", int'(err_count), ex_err);
    chk("fail_valid", int'(fail_valid), (ex_fi >= 0) ? 1 : 0);
    chk("fail_x", int'(fail_x), (ex_fi >= 0) ? ex_fi / 4 : 0);
    chk("fail_y", int'(fail_y), (ex_fi >= 0) ? ex_fi % 4 : 0);
  end

  // ---------------- stimulus ----------------
  task automatic clear_faults();
    for (int i = 0; i < NV; i++) begin
      fle[i] = 1'b0;
      feq[i] = 1'b0;
    end
  endtask

  task automatic wait_done(output int busy_cyc, input int mid_pulse);
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) busy_cyc++;
      if (mid_pulse != 0 && i == mid_pulse) begin
        start = 1'b1;
        @(negedge clock);
        if (busy) busy_cyc++;
        start = 1'b0;
      end
      if (done) break;
    end
    chk("sweep_finished", int'(done), 1);
  endtask

  task automatic run_main(output int busy_cyc, input int mid_pulse);
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
    wait_done(busy_cyc, mid_pulse);
  endtask

  int bc;

  initial begin
    clear_faults();
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err_count), 0);

    // Correct comparator
    run_main(bc, 0);
    chk("t1_busy_cycles", bc, 32);
    chk("t1_pass", int'(pass), 1);
    chk("t1_err", int'(err_count), 0);
    chk("t1_fail_valid", int'(fail_valid), 0);

    // eq tied 0: wrong whenever x==y
    for (int i = 0; i < NV; i++) feq[i] = (i / 4 == i % 4);
    run_main(bc, 0);
    chk("t2_err", int'(err_count), STOP ? 1 : 4);
    chk("t2_fail_x", int'(fail_x), 0);
    chk("t2_fail_y", int'(fail_y), 0);
    chk("t2_pass", int'(pass), 0);

    // Restart from DONE with a start pulse in the middle of the sweep
    run_main(bc, 7);
    chk("t5_busy_cycles", bc, STOP ? 2 : 32);
    chk("t5_err", int'(err_count), STOP ? 1 : 4);

    // le inverted only at x=2,y=1 (index 9)
    clear_faults();
    fle[9] = 1'b1;
    run_main(bc, 0);
    chk("t3_err", int'(err_count), 1);
    chk("t3_fail_x", int'(fail_x), 2);
    chk("t3_fail_y", int'(fail_y), 1);
    @(posedge clock); #2 start0 = 1'b1;
    @(posedge clock); #2 start0 = 1'b0;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy0) bc++;
      if (done0) break;
    end
    chk("t3_settle0_cycles", bc, STOP ? 10 : 16);
    chk("t3_settle0_err", int'(err0), 1);
    chk("t3_settle0_fx", int'(fx0), 2);
    chk("t3_settle0_fy", int'(fy0), 1);

    // Asynchronous reset ten cycles into a sweep
    clear_faults();
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("t4_x", int'(x_out), 0);
    chk("t4_y", int'(y_out), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_done", int'(done), 0);
    chk("t4_err", int'(err_count), 0);
    chk("t4_fail_valid", int'(fail_valid), 0);
    @(posedge clock); #2 resetn = 1'b1;
    run_main(bc, 0);
    chk("t4_busy_cycles", bc, 32);
    chk("t4_pass", int'(pass), 1);

    // Random fault patterns, then back-to-back sweeps with start held high
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NV; i++) begin
        fle[i] = ($urandom_range(0, 5) == 0);
        feq[i] = ($urandom_range(0, 5) == 0);
      end
      if (r == 5) begin
        @(posedge clock); #2 start = 1'b1;
        repeat (70) @(posedge clock);
        #2 start = 1'b0;
        wait_done(bc, 0);
      end else begin
        run_main(bc, 0);
      end
    end
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_sweeper.md
Name: comparator_sweeper

Overview:
- Exhaustive stimulus driver and checker for the combinational 2-operand comparators (x<=y "le", x==y "eq").
- Walks every {x,y} operand pair and drives it onto the comparator inputs.
- Samples the comparator's le/eq outputs, checks them against an internal golden compare, and reports the error count and first failing vector.
- Sits opposite the comparator on the same x/y -> le/eq interface; used on-board and in simulation as a self-checking harness.

Parameters:
- W, 2, operand width in bits for each of x and y.
- SETTLE, 1, extra wait cycles after a vector is applied before sampling. Range 0..15.
- CNT_W, 2*W+1, err_count width; holds up to 2^(2W) errors.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  level-sampled start request
- x_out  out  W  operand x to comparator
- y_out  out  W  operand y to comparator
- le_in  in  1  comparator result, expected x<=y (unsigned)
- eq_in  in  1  comparator result, expected x==y
- busy  out  1  sweep in progress
- done  out  1  sweep finished; held until restart
- pass  out  1  done and err_count==0
- err_count  out  CNT_W  number of mismatching vectors
- fail_valid  out  1  at least one mismatch captured
- fail_x  out  W  x of first mismatch
- fail_y  out  W  y of first mismatch

Behaviour:
- One clock domain. resetn is asynchronous and active-low: all state clears immediately on assertion.
- Reset values: every output 0. FSM in IDLE, vector register 0, wait counter 0.
- Vector register v is 2W bits wide.
  - x_out = v[2W-1:W], y_out = v[W-1:0]. Both are registered outputs.
  - Sweep order: v = 0, 1, ..., 2^(2W)-1, i.e. y varies fastest.
- Golden compare, unsigned: exp_le = (x_out <= y_out), exp_eq = (x_out == y_out).
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge -> APPLY next cycle with v=0, err_count=0, fail_valid=0, fail_x=0, fail_y=0.
- APPLY:
  - busy=1; vector v stays on x_out/y_out for SETTLE+1 cycles.
  - The wait counter counts 0..SETTLE. le_in/eq_in are sampled only at the edge ending the cycle where the counter equals SETTLE.
  - Mismatch (le_in!=exp_le or eq_in!=exp_eq) -> err_count += 1. If fail_valid==0, capture fail_x/fail_y from the current x_out/y_out and set fail_valid=1.
  - A vector with both bits wrong counts as one error.
  - At the sample edge, if v is not all-ones: v += 1 and the counter resets.
  - At the sample edge, if v is all-ones: go to DONE and leave v unchanged.
- Sweep latency: first APPLY cycle to first DONE cycle = 2^(2W)*(SETTLE+1) cycles. For W=2, SETTLE=1 this is 32.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - x_out/y_out hold the last vector. Results hold.
  - start=1 -> restart exactly as from IDLE, clearing all results. done drops in the first APPLY cycle.
- start is ignored while busy.
- Holding start high continuously gives back-to-back sweeps with one DONE cycle between them.
- err_count cannot overflow, given CNT_W.
- Reset mid-sweep returns to IDLE with all outputs 0. No partial results are retained.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep. At that sample edge the FSM goes to DONE with err_count=1, fail_* captured, and x_out/y_out holding the failing vector.
- Undefined: full sweep always runs, and every mismatching vector is counted.

Test Plan:
- Correct comparator model, W=2, SETTLE=1, 1-cycle start pulse -> busy for 32 cycles, x_out/y_out step (0,0),(0,1)..(3,3) every 2 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- eq_in tied 0 -> err_count=4, fail_valid=1, fail_x=0, fail_y=0, pass=0.
- le_in inverted only for x=2,y=1 -> err_count=1, fail_x=2, fail_y=1. With SETTLE=0, done asserts 16 cycles after the first APPLY cycle.
- Assert resetn low 10 cycles into a sweep -> all outputs 0 without waiting for a clock edge. A later start restarts from (0,0) and a correct model gives pass=1.
- Pulse start mid-sweep -> sweep length and results unchanged. In DONE with err_count=4, a start pulse clears err_count/fail_valid/done and restarts from v=0.
- With SWEEP_STOP_ON_FAIL_EN defined and eq_in tied 0, SETTLE=1 -> done=1 after 2 cycles, err_count=1, x_out=0, y_out=0, pass=0.
